// File: rtl/axis_uart_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of the shared FIFO+UART TX path.
// A granted source owns the output stream until its tlast beat is accepted, or
// until MAX_BEATS beats have passed, at which point it is forcibly released and
// pkt_overrun pulses. Arbitration costs one idle cycle between packets.
module axis_uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_enable,
  input  logic [NUM_REQ*WIDTH-1:0]     s_axis_data,
  input  logic [NUM_REQ-1:0]           s_axis_valid,
  input  logic [NUM_REQ-1:0]           s_axis_last,
  output logic [NUM_REQ-1:0]           s_axis_ready,
  output logic [WIDTH-1:0]             m_axis_data,
  output logic                         m_axis_valid,
  output logic                         m_axis_last,
  input  logic                         m_axis_ready,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy,
  output logic                         pkt_overrun
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BEATS + 1);

  localparam logic [GW-1:0] LAST_ID = GW'(NUM_REQ - 1);
  localparam logic [GW:0]   NREQ_W  = (GW + 1)'(NUM_REQ);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BEATS);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t               state, state_nxt;
  logic [GW-1:0]        rr_ptr;
  logic [CW-1:0]        beat_cnt;

  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   elig_rot;
  logic                 win_found;
  logic [GW:0]          win_ofs;
  logic [GW:0]          win_sum;
  logic [GW-1:0]        win_id;
  logic [GW-1:0]        next_ptr;
  logic                 accept;
  logic                 release_last;
  logic                 release_force;

  assign busy     = (state == GRANT);
  assign eligible = s_axis_valid & req_enable;

  // Rotate the eligible mask so bit 0 is the source at rr_ptr; the first set
  // bit is then the round-robin winner expressed as an offset from rr_ptr.
  assign elig_rot = NUM_REQ'({eligible, eligible} >> rr_ptr);

  // Priority search over the rotated mask, then map the offset back to an index.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    win_found = 1'b0;
    win_ofs   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (elig_rot[k]) begin
        win_found = 1'b1;
        win_ofs   = (GW + 1)'(k);
      end
    end
    win_sum = {1'b0, rr_ptr} + win_ofs;
    win_id  = (win_sum >= NREQ_W) ? GW'(win_sum - NREQ_W) : GW'(win_sum);
  end

  assign next_ptr      = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
  assign accept        = busy & s_axis_valid[grant_id] & m_axis_ready;
  assign release_last  = accept & s_axis_last[grant_id];
  // A last beat arriving exactly at the limit is an ordinary end of packet.
  assign release_force = accept & ~s_axis_last[grant_id] & ((beat_cnt + 1'b1) == MAX_CNT);

  // Pass-through of the owner's stream; everything is quiet while idle.
  always_comb begin
    m_axis_data  = '0;
    m_axis_valid = 1'b0;
    m_axis_last  = 1'b0;
    s_axis_ready = '0;
    if (busy) begin
      m_axis_data            = s_axis_data[grant_id*WIDTH +: WIDTH];
      m_axis_valid           = s_axis_valid[grant_id];
      m_axis_last            = s_axis_last[grant_id];
      s_axis_ready[grant_id] = m_axis_ready;
    end
  end

  // Next-state logic: grant on any eligible source, release on last or limit.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_found) state_nxt = GRANT;
      GRANT:   if (release_last || release_force) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, owner, round-robin pointer, beat counter and overrun pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      beat_cnt    <= '0;
      pkt_overrun <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state       <= state_nxt;
      pkt_overrun <= release_force;
      if (!busy && win_found) begin
        grant_id <= win_id;
      end
      if (release_last || release_force) begin
        rr_ptr   <= next_ptr;
        beat_cnt <= '0;
      end else if (accept) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axis_uart_tx_arbiter.sv
// Self-checking bench for axis_uart_tx_arbiter. Each source is a queue of
// beats; a packet-level reference model (owner, pointer, beat count) predicts
// the outputs every cycle, and directed scenarios pin the model with literals.
module tb_axis_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [N-1:0]     req_enable;
  logic [N*W-1:0]   s_axis_data;
  logic [N-1:0]     s_axis_valid;
  logic [N-1:0]     s_axis_last;
  logic [N-1:0]     s_axis_ready;
  logic [W-1:0]     m_axis_data;
  logic             m_axis_valid;
  logic             m_axis_last;
  logic             m_axis_ready;
  logic [1:0]       grant_id;
  logic             busy;
  logic             pkt_overrun;

  always #5 clk = ~clk;

  axis_uart_tx_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BEATS(MB)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_enable   (req_enable),
    .s_axis_data  (s_axis_data),
    .s_axis_valid (s_axis_valid),
    .s_axis_last  (s_axis_last),
    .s_axis_ready (s_axis_ready),
    .m_axis_data  (m_axis_data),
    .m_axis_valid (m_axis_valid),
    .m_axis_last  (m_axis_last),
    .m_axis_ready (m_axis_ready),
    .grant_id     (grant_id),
    .busy         (busy),
    .pkt_overrun  (pkt_overrun)
  );

  typedef struct {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  typedef struct {
    int           src;
    logic [W-1:0] d;
    logic         l;
    int           cyc;
  } acc_t;

  beat_t  q[N][$];
  acc_t   acc_log[$];
  int     grant_log[$];

  // Reference model state
  bit     m_busy;
  int     m_owner, m_rr, m_cnt;
  bit     m_ovr;

  // Stimulus control
  bit     rand_gate;
  int     ready_mode;
  bit     tgl;
  int     cyc;
  int     ovr_seen, ovr_cyc;

  int     total = 0;
  int     bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic load(input int src, input int n, input logic [W-1:0] base);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.d = base + W'(k);
      b.l = (k == n - 1);
      q[src].push_back(b);
    end
  endtask

  task automatic clear_logs();
    acc_log.delete();
    grant_log.delete();
    ovr_seen = 0;
    ovr_cyc  = -1;
  endtask

  task automatic drive();
    case (ready_mode)
      0:       m_axis_ready = 1'b1;
      1:       m_axis_ready = tgl;
      default: m_axis_ready = ($urandom_range(3) != 0);
    endcase
    for (int i = 0; i < N; i++) begin
      bit g;
      g = rand_gate ? ($urandom_range(3) != 0) : 1'b1;
      if (q[i].size() > 0) begin
        s_axis_valid[i]         = g;
        s_axis_data[i*W +: W]   = q[i][0].d;
        s_axis_last[i]          = q[i][0].l;
      end else begin
        s_axis_valid[i]         = 1'b0;
        s_axis_data[i*W +: W]   = '0;
        s_axis_last[i]          = 1'b0;
      end
    end
  endtask

  // Compare DUT outputs with the model, then advance the model by one cycle.
  task automatic compare_and_advance();
    logic [W-1:0] ed;
    logic         ev, el;
    logic [N-1:0] er;
    bit           nxt_ovr;
    beat_t        b;
    ev = 1'b0; el = 1'b0; ed = '0; er = '0; nxt_ovr = 1'b0;
    if (m_busy) begin
      ev          = s_axis_valid[m_owner];
      ed          = s_axis_data[m_owner*W +: W];
      el          = s_axis_last[m_owner];
      er[m_owner] = m_axis_ready;
    end
    check("busy",        64'(busy),         64'(m_busy));
    check("grant_id",    64'(grant_id),     64'(m_owner));
    check("pkt_overrun", 64'(pkt_overrun),  64'(m_ovr));
    check("m_valid",     64'(m_axis_valid), 64'(ev));
    check("s_ready",     64'(s_axis_ready), 64'(er));
    if (ev) begin
      check("m_data", 64'(m_axis_data), 64'(ed));
      check("m_last", 64'(m_axis_last), 64'(el));
    end
    if (pkt_overrun === 1'b1) begin
      ovr_seen++;
      ovr_cyc = cyc;
    end

    if (m_busy) begin
      if (ev && m_axis_ready) begin
        b = q[m_owner].pop_front();
        acc_log.push_back('{m_owner, b.d, b.l, cyc});
        m_cnt++;
        if (b.l || m_cnt == MB) begin
          nxt_ovr = !b.l;
          m_busy  = 1'b0;
          m_rr    = (m_owner + 1) % N;
          m_cnt   = 0;
        end
      end
      if (ready_mode == 1) tgl = !tgl;
    end else begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_rr + k) % N;
        if (s_axis_valid[j] && req_enable[j]) begin
          m_owner = j;
          m_busy  = 1'b1;
          grant_log.push_back(j);
          break;
        end
      end
    end
    m_ovr = nxt_ovr;
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    compare_and_advance();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    drive();
    rst     = 1'b0;
    m_busy  = 1'b0;
    m_owner = 0;
    m_rr    = 0;
    m_cnt   = 0;
    m_ovr   = 1'b0;
    tgl     = 1'b1;
    #1;
    check("rst_busy",    64'(busy),         64'd0);
    check("rst_grant",   64'(grant_id),     64'd0);
    check("rst_ovr",     64'(pkt_overrun),  64'd0);
    check("rst_m_valid", 64'(m_axis_valid), 64'd0);
    check("rst_m_last",  64'(m_axis_last),  64'd0);
    check("rst_m_data",  64'(m_axis_data),  64'd0);
    check("rst_s_ready", 64'(s_axis_ready), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  initial begin
    req_enable   = '1;
    s_axis_data  = '0;
    s_axis_valid = '0;
    s_axis_last  = '0;
    m_axis_ready = 1'b0;
    ready_mode   = 0;
    rand_gate    = 1'b0;
    tgl          = 1'b1;
    cyc          = 0;
    clear_logs();

    // Round robin from reset: four 2-beat packets plus a second one on source 0.
    load(0, 2, 8'h00); load(1, 2, 8'h10); load(2, 2, 8'h20); load(3, 2, 8'h30);
    load(0, 2, 8'h08);
    do_reset();
    repeat (20) step();
    begin
      int exp_grant[5] = '{0, 1, 2, 3, 0};
      logic [7:0] exp_d[10] = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21,
                                8'h30, 8'h31, 8'h08, 8'h09};
      check("rr_ngrant", 64'(grant_log.size()), 64'd5);
      for (int k = 0; k < 5; k++) check("rr_order", 64'(grant_log[k]), 64'(exp_grant[k]));
      check("rr_nbeats", 64'(acc_log.size()), 64'd10);
      for (int k = 0; k < 10; k++) check("rr_data", 64'(acc_log[k].d), 64'(exp_d[k]));
      check("rr_first_beat_cyc", 64'(acc_log[0].cyc), 64'd1);
      for (int k = 0; k < 4; k++) begin
        check("rr_in_pkt",  64'(acc_log[2*k+1].cyc - acc_log[2*k].cyc), 64'd1);
        check("rr_idle_gap", 64'(acc_log[2*k+2].cyc - acc_log[2*k+1].cyc), 64'd2);
      end
    end

    // Single packet on source 2: 0x41,0x42,0x43.
    clear_logs();
    load(2, 3, 8'h41);
    begin
      int c0;
      c0 = cyc;
      repeat (6) step();
      check("sp_grant", 64'(grant_log[0]), 64'd2);
      check("sp_nbeats", 64'(acc_log.size()), 64'd3);
      for (int k = 0; k < 3; k++) begin
        check("sp_data", 64'(acc_log[k].d),   64'(8'h41 + k));
        check("sp_last", 64'(acc_log[k].l),   64'(k == 2));
        check("sp_cyc",  64'(acc_log[k].cyc), 64'(c0 + 1 + k));
      end
    end
    // The pointer now sits at 3, so 3 wins over 0.
    clear_logs();
    load(0, 1, 8'h50); load(3, 1, 8'h53);
    repeat (6) step();
    check("sp_rr_next0", 64'(grant_log[0]), 64'd3);
    check("sp_rr_next1", 64'(grant_log[1]), 64'd0);

    // Backpressure: ready alternates 1,0,1,0 while source 1 owns the path.
    clear_logs();
    ready_mode = 1;
    tgl        = 1'b1;
    load(1, 4, 8'h60);
    repeat (12) step();
    ready_mode = 0;
    check("bp_nbeats", 64'(acc_log.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      check("bp_data", 64'(acc_log[k].d), 64'(8'h60 + k));
      check("bp_spacing", 64'(acc_log[k].cyc - acc_log[0].cyc), 64'(2 * k));
    end

    // Overrun: 6-beat packet with a 4-beat limit.
    clear_logs();
    load(0, 6, 8'h70);
    repeat (16) step();
    check("ov_ngrant",  64'(grant_log.size()), 64'd2);
    check("ov_grant0",  64'(grant_log[0]), 64'd0);
    check("ov_grant1",  64'(grant_log[1]), 64'd0);
    check("ov_nbeats",  64'(acc_log.size()), 64'd6);
    for (int k = 0; k < 6; k++) check("ov_data", 64'(acc_log[k].d), 64'(8'h70 + k));
    check("ov_beat4_nolast", 64'(acc_log[3].l), 64'd0);
    check("ov_gap", 64'(acc_log[4].cyc - acc_log[3].cyc), 64'd2);
    check("ov_pulses", 64'(ovr_seen), 64'd1);
    check("ov_pulse_cyc", 64'(ovr_cyc), 64'(acc_log[3].cyc + 1));

    // Mask: source 1 disabled while every source is valid, then reset mid-packet.
    clear_logs();
    req_enable = 4'b1101;
    for (int i = 0; i < N; i++) load(i, 3, 8'h80 + 8'(16 * i));
    repeat (6) step();
    begin
      bit reached;
      reached = 1'b0;
      for (int k = 0; k < 20; k++) begin
        if (m_busy && m_cnt >= 1) begin
          reached = 1'b1;
          break;
        end
        step();
      end
      check("mk_midpkt_reached", 64'(reached), 64'd1);
    end
    check("mk_busy_before_rst", 64'(busy), 64'd1);
    foreach (acc_log[k]) check("mk_src1_never", 64'(acc_log[k].src == 1), 64'd0);
    for (int i = 0; i < N; i++) q[i].delete();
    for (int i = 0; i < N; i++) load(i, 1, 8'hA0 + 8'(i));
    clear_logs();
    do_reset();
    repeat (8) step();
    check("mk_restart0", 64'(grant_log[0]), 64'd0);
    check("mk_restart1", 64'(grant_log[1]), 64'd2);

    // Randomized traffic against the model.
    rand_gate  = 1'b1;
    ready_mode = 2;
    for (int t = 0; t < 3000; t++) begin
      if (t % 64 == 0) req_enable = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++)
        if (q[i].size() == 0 && $urandom_range(3) == 0)
          load(i, $urandom_range(1, 6), W'($urandom));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_uart_tx_arbiter.md
Name: axis_uart_tx_arbiter

Overview:
Packet-granular round-robin arbiter that shares the single AXI-Stream FIFO+UART TX path between NUM_REQ stream sources. Once granted, a source keeps the path until its tlast beat is accepted, so bytes from different packets never interleave on the serial line. The arbiter sits between the requesting stream masters and the s_axis port of axis_fifo_uart_tx. It reports the current owner and flags packets that exceed the length limit.

Parameters:
NUM_REQ, 4, number of requesting stream sources (2..8)
WIDTH, 8, data width per beat
MAX_BEATS, 32, maximum beats per packet before forced release (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
req_enable  in  NUM_REQ  per-source arbitration enable mask
s_axis_data  in  NUM_REQ*WIDTH  source data; source i occupies bits [i*WIDTH +: WIDTH]
s_axis_valid  in  NUM_REQ  per-source valid
s_axis_last  in  NUM_REQ  per-source last
s_axis_ready  out  NUM_REQ  per-source ready
m_axis_data  out  WIDTH  data to FIFO/UART TX
m_axis_valid  out  1  valid to FIFO/UART TX
m_axis_last  out  1  last to FIFO/UART TX
m_axis_ready  in  1  ready from FIFO/UART TX
grant_id  out  clog2(NUM_REQ)  index of the current/last owner
busy  out  1  high while a packet is owned (state GRANT)
pkt_overrun  out  1  one-cycle pulse on forced release

Behaviour:
- Reset (rst=0, async): state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0, busy=0, pkt_overrun=0. All outputs are 0 while reset is held, including s_axis_ready, m_axis_valid, m_axis_last and m_axis_data. Reset in mid-packet drops the packet with no tail beat.
- States: IDLE, GRANT.
- IDLE:
  - eligible[i] = s_axis_valid[i] & req_enable[i].
  - If any source is eligible, select the first eligible index searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Register the selection into grant_id and go to GRANT. The decision costs one cycle; no beat is transferred in IDLE.
  - If no source is eligible, stay in IDLE.
  - In IDLE, m_axis_valid=0 and all s_axis_ready=0.
- GRANT (combinational pass-through, g=grant_id):
  - m_axis_data = s_axis_data[g], m_axis_valid = s_axis_valid[g], m_axis_last = s_axis_last[g].
  - s_axis_ready[g] = m_axis_ready. s_axis_ready of every other source is 0.
  - A beat is accepted when m_axis_valid & m_axis_ready. Each accepted beat increments beat_cnt.
- Release:
  - On an accepted beat with m_axis_last=1: go to IDLE, set rr_ptr=(g+1) mod NUM_REQ, clear beat_cnt.
  - On an accepted beat without last where beat_cnt+1 == MAX_BEATS: go to IDLE, pulse pkt_overrun for one cycle, set rr_ptr=(g+1) mod NUM_REQ, clear beat_cnt. The source's remaining beats compete again as a new packet.
  - Last beat and limit reached on the same beat: treat as a normal last; no pkt_overrun.
- Minimum gap between packets is one idle cycle, so at most one packet per (beats+1) cycles.
- Mid-packet conditions: req_enable is sampled only in IDLE, so deasserting it mid-packet does not cut the packet. A source dropping valid mid-packet holds the grant indefinitely; there is no timeout.
- busy = (state==GRANT). grant_id holds its last value in IDLE.
- beat_cnt width is clog2(MAX_BEATS+1) and never wraps.
- Combinational paths from m_axis_ready to s_axis_ready and from s_axis_* to m_axis_* are allowed. No path exists from inputs to busy or grant_id.

Test Plan:
- Single packet: source 2 sends 3 bytes 0x41,0x42,0x43 with last on 0x43, m_axis_ready=1. Required: grant_id=2 one cycle after valid; 3 consecutive m_axis beats with last on the third; busy falls the cycle after; rr_ptr=3.
- Round robin: all 4 sources hold 2-beat packets simultaneously, starting from reset. Required: grant order 0,1,2,3,0; one idle cycle between packets; no interleaving of bytes between packets.
- Backpressure: m_axis_ready toggles 1,0,1,0 during a 4-beat packet from source 1. Required: s_axis_ready[1] tracks m_axis_ready exactly; beat order is preserved; no duplicated or lost beats.
- Overrun: MAX_BEATS=4, source 0 streams 6 beats with last on the 6th, source 3 idle. Required: pkt_overrun pulses after beat 4; re-grant to source 0 after the idle cycle; beats 5–6 follow; no second pulse.
- Mask and reset: req_enable=4'b1101 with all sources valid. Required: source 1 is never granted. Then assert rst low mid-packet: outputs clear immediately; after release, arbitration restarts at source 0.
